// File: rtl/simon_ctrl.sv
// Load/run/output sequencer for the nibble-serial Simon32/64 core; issues strobes and indices only.
// Optional LOAD inactivity abort with o_err port: define SIMON_CTRL_TIMEOUT_EN.
module simon_ctrl #(
   parameter int ROUNDS      = 32,
   parameter int KEY_WORDS   = 4,
   parameter int PT_NIBBLES  = 8,
   parameter int KEY_NIBBLES = 16,
   parameter int OUT_NIBBLES = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_shift,
   input  logic       i_out_ack,
   output logic       o_load_pt,
   output logic       o_load_key,
   output logic [4:0] o_nib_idx,
   output logic       o_z_rst,
   output logic       o_z_step,
   output logic       o_round_en,
   output logic [5:0] o_round,
   output logic       o_out_valid,
   output logic [2:0] o_out_idx,
   output logic       o_busy,
`ifdef SIMON_CTRL_TIMEOUT_EN
   output logic       o_err,
`endif
   output logic       o_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

   localparam logic [4:0] LAST_NIB    = 5'(PT_NIBBLES + KEY_NIBBLES - 1);
   localparam logic [4:0] PT_LIMIT    = 5'(PT_NIBBLES);
   localparam logic [5:0] LAST_ROUND  = 6'(ROUNDS - 1);
   localparam logic [5:0] STEP_ROUNDS = 6'(ROUNDS - KEY_WORDS);
   localparam logic [2:0] LAST_OUT    = 3'(OUT_NIBBLES - 1);

   state_t     state, state_nxt;
   logic [4:0] nib, nib_nxt;
   logic [5:0] round, round_nxt;
   logic [2:0] out, out_nxt;
   logic       done_q, done_nxt;
   logic       load_phase;
`ifdef SIMON_CTRL_TIMEOUT_EN
   logic [7:0] idle_cnt, idle_cnt_nxt;
   logic       err_q, err_nxt;
`endif

   // NOTE: synchronous reset -- i_rst is only looked at on the rising edge, so it sits inside the clocked branch.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         nib      <= '0;
         round    <= '0;
         out      <= '0;
         done_q   <= 1'b0;
`ifdef SIMON_CTRL_TIMEOUT_EN
         idle_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         nib      <= nib_nxt;
         round    <= round_nxt;
         out      <= out_nxt;
         done_q   <= done_nxt;
`ifdef SIMON_CTRL_TIMEOUT_EN
         idle_cnt <= idle_cnt_nxt;
         err_q    <= err_nxt;
`endif
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nxt   = state;
      nib_nxt     = nib;
      round_nxt   = round;
      out_nxt     = out;
      done_nxt    = 1'b0;
      o_nib_idx   = '0;
      o_z_rst     = 1'b0;
      o_z_step    = 1'b0;
      o_round_en  = 1'b0;
      o_round     = '0;
      o_out_valid = 1'b0;
      o_out_idx   = '0;
`ifdef SIMON_CTRL_TIMEOUT_EN
      idle_cnt_nxt = '0;
      err_nxt      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            o_z_rst = 1'b1;
            if (i_shift) begin
               state_nxt = LOAD;
               nib_nxt   = 5'd1;
            end
         end
         LOAD: begin
            o_z_rst   = 1'b1;
            o_nib_idx = nib;
            if (i_shift) begin
               if (nib == LAST_NIB) begin
                  state_nxt = RUN;
                  nib_nxt   = '0;
                  round_nxt = '0;
               end else begin
                  nib_nxt = nib + 5'd1;
               end
`ifdef SIMON_CTRL_TIMEOUT_EN
            end else if (idle_cnt == 8'd254) begin
               // 255th consecutive idle cycle: drop the partial load
               state_nxt = IDLE;
               nib_nxt   = '0;
               err_nxt   = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + 8'd1;
`endif
            end
         end
         RUN: begin
            o_round_en = 1'b1;
            o_round    = round;
            o_z_step   = (round < STEP_ROUNDS);
            if (round == LAST_ROUND) begin
               state_nxt = OUT;
               round_nxt = '0;
               out_nxt   = '0;
            end else begin
               round_nxt = round + 6'd1;
            end
         end
         OUT: begin
            o_out_valid = 1'b1;
            o_out_idx   = out;
            if (i_out_ack) begin
               if (out == LAST_OUT) begin
                  state_nxt = IDLE;
                  out_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  out_nxt = out + 3'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load_phase = (state == IDLE) || (state == LOAD);
   assign o_load_pt  = i_shift && load_phase && (o_nib_idx <  PT_LIMIT);
   assign o_load_key = i_shift && load_phase && (o_nib_idx >= PT_LIMIT);
   assign o_busy     = (state != IDLE);
   assign o_done     = done_q;
`ifdef SIMON_CTRL_TIMEOUT_EN
   assign o_err      = err_q;
`endif

endmodule

// File: tb/tb_simon_ctrl.sv
// Randomized bench for simon_ctrl against a transaction-count reference model.
// Exercises the LOAD timeout too when SIMON_CTRL_TIMEOUT_EN is defined.
module tb_simon_ctrl;

   localparam int ROUNDS    = 32;
   localparam int KEY_WORDS = 4;
   localparam int PT_N      = 8;
   localparam int LOAD_N    = 24;
   localparam int OUT_N     = 8;

   logic       i_clk = 1'b0;
   logic       i_rst, i_shift, i_out_ack;
   logic       o_load_pt, o_load_key, o_z_rst, o_z_step, o_round_en;
   logic       o_out_valid, o_busy, o_done;
   logic [4:0] o_nib_idx;
   logic [5:0] o_round;
   logic [2:0] o_out_idx;
`ifdef SIMON_CTRL_TIMEOUT_EN
   logic       o_err;
`endif

   int checks = 0;
   int failures = 0;

   // reference model: progress counted in nibbles loaded, rounds done, nibbles acked
   int m_loaded, m_rounds, m_acked, m_gap;
   bit m_done, m_err;

   simon_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_shift(i_shift), .i_out_ack(i_out_ack),
      .o_load_pt(o_load_pt), .o_load_key(o_load_key), .o_nib_idx(o_nib_idx),
      .o_z_rst(o_z_rst), .o_z_step(o_z_step), .o_round_en(o_round_en),
      .o_round(o_round), .o_out_valid(o_out_valid), .o_out_idx(o_out_idx),
      .o_busy(o_busy),
`ifdef SIMON_CTRL_TIMEOUT_EN
      .o_err(o_err),
`endif
      .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_loaded = 0; m_rounds = 0; m_acked = 0; m_gap = 0;
      m_done = 0; m_err = 0;
   endtask

   // one clock: drive at negedge, compare outputs, then advance the model
   task automatic step(input logic sh, input logic ack, input logic rst);
      bit loading, running, outputting;
      @(negedge i_clk);
      i_shift = sh; i_out_ack = ack; i_rst = rst;
      #1;
      loading    = (m_loaded < LOAD_N);
      running    = (m_loaded == LOAD_N) && (m_rounds < ROUNDS);
      outputting = (m_loaded == LOAD_N) && (m_rounds == ROUNDS);
      check("busy",      o_busy,      int'(m_loaded != 0));
      check("z_rst",     o_z_rst,     int'(loading));
      check("nib_idx",   o_nib_idx,   loading ? m_loaded : 0);
      check("load_pt",   o_load_pt,   int'(loading && sh && m_loaded < PT_N));
      check("load_key",  o_load_key,  int'(loading && sh && m_loaded >= PT_N));
      check("round_en",  o_round_en,  int'(running));
      check("round",     o_round,     running ? m_rounds : 0);
      check("z_step",    o_z_step,    int'(running && m_rounds < ROUNDS - KEY_WORDS));
      check("out_valid", o_out_valid, int'(outputting));
      check("out_idx",   o_out_idx,   outputting ? m_acked : 0);
      check("done",      o_done,      int'(m_done));
`ifdef SIMON_CTRL_TIMEOUT_EN
      check("err",       o_err,       int'(m_err));
`endif
      if (rst) begin
         model_clear();
      end else begin
         m_done = 0;
         m_err  = 0;
         if (loading) begin
            if (sh) begin
               m_loaded++;
               m_gap = 0;
            end else if (m_loaded > 0) begin
`ifdef SIMON_CTRL_TIMEOUT_EN
               m_gap++;
               if (m_gap == 255) begin
                  m_loaded = 0; m_gap = 0; m_err = 1;
               end
`endif
            end
         end else if (running) begin
            m_rounds++;
         end else if (outputting && ack) begin
            m_acked++;
            if (m_acked == OUT_N) begin
               m_loaded = 0; m_rounds = 0; m_acked = 0; m_done = 1;
            end
         end
      end
   endtask

   // sh_mode: 0 always high, 1 pattern 1,0,0, 2 random; ack_mode: 0 every other cycle, 1 random
   task automatic run_txn(input string tag, input int sh_mode, input int ack_mode);
      int  k;
      bit  fin;
      logic sh, ack;
      k = 0; fin = 0;
      while (!fin && k < 1000) begin
         case (sh_mode)
            0:       sh = 1'b1;
            1:       sh = (k % 3 == 0);
            default: sh = 1'($urandom_range(0, 1));
         endcase
         ack = (ack_mode == 0) ? (k % 2 == 1) : 1'($urandom_range(0, 1));
         step(sh, ack, 1'b0);
         k++;
         if (m_done) fin = 1;
      end
      if (!fin) check({tag, "_budget"}, 0, 1);
   endtask

   task automatic run_until_round(input int r);
      int k;
      k = 0;
      while (!(m_loaded == LOAD_N && m_rounds == r) && k < 500) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         k++;
      end
      if (k >= 500) check("reach_round_budget", 0, 1);
   endtask

   task automatic run_until_ack(input int idx);
      int k;
      k = 0;
      while (!(m_loaded == LOAD_N && m_rounds == ROUNDS && m_acked == idx) && k < 500) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         k++;
      end
      if (k >= 500) check("reach_out_budget", 0, 1);
   endtask

   initial begin
      i_rst = 1'b1; i_shift = 1'b0; i_out_ack = 1'b0;
      repeat (2) @(posedge i_clk);
      model_clear();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);

      run_txn("consecutive", 0, 0);
      step(1'b1, 1'b0, 1'b0);           // i_shift on the done cycle starts a load
      run_txn("continued", 0, 1);
      step(1'b0, 1'b0, 1'b0);
      run_txn("gapped", 1, 0);
      step(1'b0, 1'b0, 1'b0);

      run_until_round(10);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      run_until_ack(3);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      run_txn("after_reset", 0, 0);
      step(1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         run_txn("random", 2, 1);
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

`ifdef SIMON_CTRL_TIMEOUT_EN
      step(1'b1, 1'b0, 1'b1);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      repeat (254) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);           // continues at index 5
      repeat (255) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);           // err pulse, back in IDLE
      step(1'b0, 1'b0, 1'b0);
      run_txn("post_timeout", 0, 0);
      step(1'b0, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/simon_ctrl.md
# simon_ctrl

Sequencer for the nibble-serial Simon32/64 core. It owns the load, run and output phases:
- accepts 24 input nibbles (8 plaintext, 16 key) from the pin-limited shift interface;
- runs the round datapath for ROUNDS cycles, including the z0 sequence generator reset/step and key-schedule update strobes;
- then presents 8 ciphertext nibbles with an acknowledge handshake.

It sits between the top-level pin wrapper and the `simon` datapath/`lfsr_z0`. It issues strobes and indices only and holds no cipher state.

## Interface
- ROUNDS, 32, total rounds (legal 5..63)
- KEY_WORDS, 4, key words m; key-schedule updates issued on rounds 0..ROUNDS-KEY_WORDS-1
- PT_NIBBLES, 8, plaintext nibbles loaded first
- KEY_NIBBLES, 16, key nibbles loaded after plaintext
- OUT_NIBBLES, 8, ciphertext nibbles presented

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_shift  in  1  load strobe; one nibble accepted per cycle it is high (IDLE/LOAD only)
- i_out_ack  in  1  consumer accepted current output nibble
- o_load_pt  out  1  write datapath plaintext nibble o_nib_idx this cycle
- o_load_key  out  1  write datapath key nibble o_nib_idx-PT_NIBBLES this cycle
- o_nib_idx  out  5  load nibble index 0..PT_NIBBLES+KEY_NIBBLES-1
- o_z_rst  out  1  drives lfsr_z0 i_rst
- o_z_step  out  1  advance z0 LFSR / key schedule this cycle
- o_round_en  out  1  datapath performs one round this cycle
- o_round  out  6  current round index
- o_out_valid  out  1  ciphertext nibble o_out_idx available
- o_out_idx  out  3  output nibble index
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after final output ack

## Operation
States: IDLE, LOAD, RUN, OUT. Registers: state, nib counter (5b), round counter (6b), out counter (3b).

IDLE:
- o_z_rst=1.
- i_shift=1: accept nibble 0, go to LOAD with nib=1.

LOAD:
- o_z_rst=1.
- Each i_shift=1 cycle accepts nibble nib, then nib++.
- i_shift=0 holds all state (pause allowed, no limit unless SIMON_CTRL_TIMEOUT_EN).
- Accepting index PT_NIBBLES+KEY_NIBBLES-1 (23) moves to RUN with round=0.

Load strobes (combinational):
- o_load_pt = i_shift & (IDLE|LOAD) & idx<PT_NIBBLES
- o_load_key = same gating with idx≥PT_NIBBLES
- o_nib_idx = 0 in IDLE, nib in LOAD

RUN:
- o_round_en=1 and o_round=round every cycle.
- o_z_step=1 while round < ROUNDS-KEY_WORDS (28).
- round++ each cycle; after round ROUNDS-1, go to OUT with out=0.
- i_shift is ignored.

OUT:
- o_out_valid=1, o_out_idx=out.
- i_out_ack=1 increments out. Ack on idx OUT_NIBBLES-1 goes to IDLE and sets registered o_done for the next cycle.
- i_out_ack outside OUT is ignored; i_shift in OUT is ignored.

Reset (any state, including mid-LOAD/RUN/OUT):
- next cycle state=IDLE and all counters=0;
- outputs o_load_*=0 (unless i_shift), o_round_en=0, o_z_step=0, o_out_valid=0, o_busy=0, o_done=0, o_z_rst=1, indices 0.

## Timing
- Nibble accepted in the same cycle i_shift is high; no back-pressure on the load side.
- Last load nibble at cycle t → o_round_en high cycles t+1..t+ROUNDS → o_out_valid first high at t+ROUNDS+1.
- o_z_rst falls the cycle RUN is entered, so lfsr_z0 leaves reset at RUN cycle 0 and its first output is the z0 bit for round 0.
- Output handshake: nibble transfers on the edge where o_out_valid&i_out_ack. Back-to-back acks give one nibble per cycle.
- o_done high exactly one cycle, coincident with IDLE. An i_shift that cycle starts a new load.

## Configuration
- SIMON_CTRL_TIMEOUT_EN defined:
  - an 8-bit idle counter runs in LOAD; it resets on each i_shift=1.
  - at 255 consecutive i_shift=0 cycles: abort to IDLE, pulse o_err (extra output, 1 bit, reset 0) for one cycle; partial load discarded.
- Undefined: no counter, no o_err port; LOAD waits indefinitely.

## Test plan
- Reset then 24 consecutive i_shift cycles → o_load_pt on idx 0..7, o_load_key on 8..23; o_round_en exactly 32 cycles, o_round 0..31; o_z_step on rounds 0..27 only.
- Load with i_shift gaps (pattern 1,0,0,1...) → nib holds during gaps; RUN entered only after 24 accepted nibbles.
- OUT with i_out_ack every other cycle → o_out_idx 0..7 each held until acked; o_done single pulse after idx 7 ack; o_busy falls the same cycle.
- i_rst asserted at round 10 and again mid-OUT (idx 3) → IDLE next cycle, o_z_rst=1, o_round_en=0, o_out_valid=0; a fresh 24-nibble load then runs a full 32 rounds.
- i_shift held high through RUN/OUT and i_out_ack during LOAD/RUN → no state effect.
- With SIMON_CTRL_TIMEOUT_EN: load 5 nibbles, idle 255 cycles → o_err pulse, state IDLE. Idle of 254 cycles then i_shift → load continues at idx 5.
